// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a per-register
// busy scoreboard.
//
// - Reads are combinational on NRD ports.
// - Two synchronous write ports; port 1 wins on an address collision.
// - Issue logic reserves registers with rsv_en/rsv_addr.
// - A writeback clears the busy bit unless the same register is reserved
//   in that cycle.
// - ZERO_REG = 1 makes register 0 a constant zero that is never busy.
//
// Optional feature, macro REGFILE_MP_BYPASS_EN: write-to-read forwarding,
// so a read of a register being written this cycle sees the incoming data.
module regfile_mp #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 we0,
  input  logic [AW-1:0]        wa0,
  input  logic [WIDTH-1:0]     wd0,
  input  logic                 we1,
  input  logic [AW-1:0]        wa1,
  input  logic [WIDTH-1:0]     wd1,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic [DEPTH-1:0]     busy_vec
);

  localparam bit zeroEn = (ZERO_REG != 0);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]            busy_q, busy_d;

  // Accesses aimed at a hardwired zero register are dropped up front, so
  // neither the storage update nor the forwarding path has to recheck them.
  logic wr0Ok, wr1Ok, rsvOk;
  assign wr0Ok = we0    && !(zeroEn && (wa0 == '0));
  assign wr1Ok = we1    && !(zeroEn && (wa1 == '0));
  assign rsvOk = rsv_en && !(zeroEn && (rsv_addr == '0));

  // Next state: port 0 first, then port 1 so it overrides on a shared
  // address; writes clear busy, and a reserve applied last re-sets it
  // because the new producer supersedes the one completing now.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0Ok) begin
      regs_d[wa0] = wd0;
      busy_d[wa0] = 1'b0;
    end
    if (wr1Ok) begin
      regs_d[wa1] = wd1;
      busy_d[wa1] = 1'b0;
    end
    if (rsvOk) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (zeroEn) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  // Storage and scoreboard flops; reset wipes both and discards any
  // write or reserve pending in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar k = 0; k < NRD; k++) begin : g_read
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             busy;

    assign addr = ra[k*AW +: AW];

    // Per-port read: flop contents, optionally overridden by a write in
    // flight (never while reset is held, since that write cannot commit).
    always_comb begin
      data = regs_q[addr];
      busy = busy_q[addr];
`ifdef REGFILE_MP_BYPASS_EN
      if (!rst && wr0Ok && (wa0 == addr)) begin
        data = wd0;
        busy = rsvOk && (rsv_addr == addr);
      end
      if (!rst && wr1Ok && (wa1 == addr)) begin
        data = wd1;
        busy = rsvOk && (rsv_addr == addr);
      end
`endif
      if (zeroEn && (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd[k*WIDTH +: WIDTH] = data;
    assign rd_busy[k]           = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp.
// The stimulus process queues hand-computed expectations for the current
// cycle. A monitor on the falling edge pops and compares them against the
// DUT outputs. Instance A uses the default parameters. Instance B uses
// DEPTH = 16, NRD = 3 and ZERO_REG = 1.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  // Instance A signals (WIDTH 8, DEPTH 8, NRD 2)
  logic [5:0]  raA;
  logic [15:0] rdA;
  logic [1:0]  rdBusyA;
  logic        we0A, we1A, rsvA;
  logic [2:0]  wa0A, wa1A, rsvAddrA;
  logic [7:0]  wd0A, wd1A;
  logic [7:0]  busyVecA;

  // Instance B signals (WIDTH 8, DEPTH 16, NRD 3, ZERO_REG 1)
  logic [11:0] raB;
  logic [23:0] rdB;
  logic [2:0]  rdBusyB;
  logic        we0B, we1B, rsvB;
  logic [3:0]  wa0B, wa1B, rsvAddrB;
  logic [7:0]  wd0B, wd1B;
  logic [15:0] busyVecB;

  regfile_mp #(.WIDTH(8), .DEPTH(8), .NRD(2), .ZERO_REG(0)) dutA (
    .clk(clk), .rst(rst), .ra(raA), .rd(rdA), .rd_busy(rdBusyA),
    .we0(we0A), .wa0(wa0A), .wd0(wd0A),
    .we1(we1A), .wa1(wa1A), .wd1(wd1A),
    .rsv_en(rsvA), .rsv_addr(rsvAddrA), .busy_vec(busyVecA)
  );

  regfile_mp #(.WIDTH(8), .DEPTH(16), .NRD(3), .ZERO_REG(1)) dutB (
    .clk(clk), .rst(rst), .ra(raB), .rd(rdB), .rd_busy(rdBusyB),
    .we0(we0B), .wa0(wa0B), .wd0(wd0B),
    .we1(we1B), .wa1(wa1B), .wd1(wd1B),
    .rsv_en(rsvB), .rsv_addr(rsvAddrB), .busy_vec(busyVecB)
  );

  typedef struct {
    string       name;
    logic [15:0] rd;
    logic [1:0]  busy;
    logic [7:0]  vec;
  } expA_t;

  typedef struct {
    string       name;
    logic [23:0] rd;
    logic [2:0]  busy;
    logic [15:0] vec;
  } expB_t;

  expA_t qA[$];
  expB_t qB[$];
  expA_t eA;
  expB_t eB;

  int checks   = 0;
  int failures = 0;

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: drain every expectation queued for this cycle on the falling edge
  always @(negedge clk) begin
    while (qA.size() > 0) begin
      eA = qA.pop_front();
      cmp({eA.name, ".rd"},       {16'h0, rdA},      {16'h0, eA.rd});
      cmp({eA.name, ".rd_busy"},  {30'h0, rdBusyA},  {30'h0, eA.busy});
      cmp({eA.name, ".busy_vec"}, {24'h0, busyVecA}, {24'h0, eA.vec});
    end
    while (qB.size() > 0) begin
      eB = qB.pop_front();
      cmp({eB.name, ".rd"},       {8'h0, rdB},       {8'h0, eB.rd});
      cmp({eB.name, ".rd_busy"},  {29'h0, rdBusyB},  {29'h0, eB.busy});
      cmp({eB.name, ".busy_vec"}, {16'h0, busyVecB}, {16'h0, eB.vec});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                               input logic w1, input logic [2:0] a1, input logic [7:0] d1,
                               input logic rs, input logic [2:0] rsa,
                               input logic [2:0] r1, input logic [2:0] r0);
    we0A = w0; wa0A = a0; wd0A = d0;
    we1A = w1; wa1A = a1; wd1A = d1;
    rsvA = rs; rsvAddrA = rsa;
    raA  = {r1, r0};
  endtask

  task automatic applyStimulusB(input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                                input logic w1, input logic [3:0] a1, input logic [7:0] d1,
                                input logic rs, input logic [3:0] rsa,
                                input logic [3:0] r2, input logic [3:0] r1, input logic [3:0] r0);
    we0B = w0; wa0B = a0; wd0B = d0;
    we1B = w1; wa1B = a1; wd1B = d1;
    rsvB = rs; rsvAddrB = rsa;
    raB  = {r2, r1, r0};
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expRd,
                             input logic [1:0] expBusy, input logic [7:0] expVec);
    expA_t e;
    e.name = name; e.rd = expRd; e.busy = expBusy; e.vec = expVec;
    qA.push_back(e);
  endtask

  task automatic checkOutputB(input string name, input logic [23:0] expRd,
                              input logic [2:0] expBusy, input logic [15:0] expVec);
    expB_t e;
    e.name = name; e.rd = expRd; e.busy = expBusy; e.vec = expVec;
    qB.push_back(e);
  endtask

  // Directed sequence; each expectation describes the cycle it is queued in
  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    applyStimulusB(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    step();
    checkOutput("reset_init", 16'h0000, 2'b00, 8'h00);
    step();
    rst = 1'b0;

    // Preload, then check the values and a reserve land
    applyStimulus(1, 1, 8'h77, 1, 7, 8'h99, 1, 2, 7, 1);
    checkOutput("pre_write", BYP ? 16'h9977 : 16'h0000, 2'b00, 8'h00);
    step();
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 2, 1);
    checkOutput("preload", 16'h0077, 2'b10, 8'h04);
    step();

    // Asynchronous reset between edges with a write and reserve pending
    applyStimulus(1, 1, 8'h55, 0, 0, 8'h00, 1, 3, 7, 1);
    #2 rst = 1'b1;
    #1 checkOutput("reset_async", 16'h0000, 2'b00, 8'h00);
    step();
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 7, 1);
    rst = 1'b0;
    checkOutput("reset_release", 16'h0000, 2'b00, 8'h00);
    step();
    checkOutput("reset_hold", 16'h0000, 2'b00, 8'h00);
    step();

    // Dual write to distinct addresses
    applyStimulus(1, 3, 8'hA5, 1, 5, 8'h3C, 0, 0, 5, 3);
    checkOutput("dual_same", BYP ? 16'h3CA5 : 16'h0000, 2'b00, 8'h00);
    step();
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 3);
    checkOutput("dual_write", 16'h3CA5, 2'b00, 8'h00);
    step();

    // Collision: port 1 wins
    applyStimulus(1, 2, 8'h11, 1, 2, 8'h22, 0, 0, 2, 2);
    checkOutput("collide_same", BYP ? 16'h2222 : 16'h0000, 2'b00, 8'h00);
    step();
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 2, 2);
    checkOutput("collision", 16'h2222, 2'b00, 8'h00);
    step();

    // Scoreboard: reserve 4
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1, 4, 4, 0);
    checkOutput("rsv_same", 16'h0000, 2'b00, 8'h00);
    step();
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 4, 0);
    checkOutput("rsv_busy", 16'h0000, 2'b10, 8'h10);
    step();

    // Write and reserve 4 together: reserve wins
    applyStimulus(1, 4, 8'hC3, 0, 0, 8'h00, 1, 4, 4, 0);
    checkOutput("wr_rsv_same", BYP ? 16'hC300 : 16'h0000, 2'b10, 8'h10);
    step();
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 4, 0);
    checkOutput("wr_rsv_after", 16'hC300, 2'b10, 8'h10);
    step();

    // Write 4 alone on port 1 clears busy
    applyStimulus(0, 0, 8'h00, 1, 4, 8'hD4, 0, 0, 4, 0);
    checkOutput("clr_same", BYP ? 16'hD400 : 16'hC300, BYP ? 2'b00 : 2'b10, 8'h10);
    step();
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 4, 0);
    checkOutput("clr_after", 16'hD400, 2'b00, 8'h00);
    step();

    // Same-cycle read of an address being written
    applyStimulus(1, 6, 8'h5A, 0, 0, 8'h00, 0, 0, 0, 6);
    checkOutput("bypass_same", BYP ? 16'h005A : 16'h0000, 2'b00, 8'h00);
    step();
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 6);
    checkOutput("bypass_after", 16'h005A, 2'b00, 8'h00);
    step();

    // Port 0 write clears busy
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 1);
    checkOutput("rsv1_same", 16'h0000, 2'b00, 8'h00);
    step();
    applyStimulus(1, 1, 8'hE1, 0, 0, 8'h00, 0, 0, 1, 1);
    checkOutput("clr0_same", BYP ? 16'hE1E1 : 16'h0000, BYP ? 2'b00 : 2'b11, 8'h02);
    step();
    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 1);
    checkOutput("clr0_after", 16'hE1E1, 2'b00, 8'h00);
    step();

    // Instance B: register 0 is hardwired zero
    applyStimulusB(1, 0, 8'hFF, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    checkOutputB("z_same", 24'h000000, 3'b000, 16'h0000);
    step();
    applyStimulusB(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    checkOutputB("z_after", 24'h000000, 3'b000, 16'h0000);
    step();

    // Instance B: address 15 behaves normally on all three ports
    applyStimulusB(0, 0, 8'h00, 1, 15, 8'h81, 0, 0, 15, 15, 15);
    checkOutputB("r15_same", BYP ? 24'h818181 : 24'h000000, 3'b000, 16'h0000);
    step();
    applyStimulusB(0, 0, 8'h00, 0, 0, 8'h00, 1, 15, 15, 15, 15);
    checkOutputB("r15_data", 24'h818181, 3'b000, 16'h0000);
    step();
    applyStimulusB(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 15, 15, 15);
    checkOutputB("r15_busy", 24'h818181, 3'b111, 16'h8000);
    step();
    applyStimulusB(1, 0, 8'hFF, 0, 0, 8'h00, 0, 0, 0, 15, 0);
    checkOutputB("z_bypass", 24'h008100, 3'b010, 16'h8000);
    step();
    applyStimulusB(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);

    // Let the monitor drain, bounded
    repeat (3) step();
    checks++;
    if (qA.size() != 0 || qB.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", qA.size() + qB.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
